// File: rtl/ycbcr2rgb_pipe.sv
// rtl/ycbcr2rgb_pipe.sv - streaming YCbCr 4:4:4 to RGB converter, 3-stage pipeline with backpressure
module ycbcr2rgb_pipe #(
   parameter int DW   = 8,
   parameter int FRAC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3*DW-1:0] in_data,
   input  logic            in_mode,
   input  logic            in_sof,
   input  logic            in_eol,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3*DW-1:0] out_data,
   output logic            out_sof,
   output logic            out_eol
);

   // Accumulator wide enough for the largest coefficient times a (DW+1)-bit signed operand.
   localparam int ACCW = DW + 12;
   localparam int CW   = DW + 1;

   localparam logic [CW-1:0]          C_OFF = CW'(1 << (DW - 1));
   localparam logic [CW-1:0]          Y_OFF = CW'(16 << (DW - 8));
   localparam logic signed [ACCW-1:0] RND   = ACCW'(1 << (FRAC - 1));
   localparam logic signed [ACCW-1:0] MAXV  = ACCW'((1 << DW) - 1);

   // Saturate a post-shift channel value into the unsigned DW-bit output range.
   function automatic logic [DW-1:0] clip(input logic signed [ACCW-1:0] v);
      if (v < 0) begin
         return '0;
      end
      if (v > MAXV) begin
         return '1;
      end
      return v[DW-1:0];
   endfunction

   // Pipeline enable: a bubble in the output stage lets everything advance regardless of out_ready.
   logic en;
   logic accept;
   logic out_valid_q;

   assign en       = out_ready | ~out_valid_q;
   assign in_ready = en;
   assign accept   = in_valid & en;

   // ---------------- Stage 1: remove offsets ----------------
   logic [DW-1:0]        y_in, cb_in, cr_in;
   logic                 s1_valid_d, s1_valid_q;
   logic signed [CW-1:0] s1_y_d, s1_y_q;
   logic signed [CW-1:0] s1_cb_d, s1_cb_q;
   logic signed [CW-1:0] s1_cr_d, s1_cr_q;
   logic                 s1_mode_d, s1_mode_q;
   logic                 s1_sof_d, s1_sof_q;
   logic                 s1_eol_d, s1_eol_q;

   assign y_in  = in_data[DW-1:0];
   assign cb_in = in_data[2*DW-1:DW];
   assign cr_in = in_data[3*DW-1:2*DW];

   // Centre chroma on zero and drop the studio black level for limited-range beats.
   always_comb begin
      s1_valid_d = accept;
      s1_y_d     = {1'b0, y_in} - (in_mode ? Y_OFF : '0);
      s1_cb_d    = {1'b0, cb_in} - C_OFF;
      s1_cr_d    = {1'b0, cr_in} - C_OFF;
      s1_mode_d  = in_mode;
      s1_sof_d   = in_sof & accept;
      s1_eol_d   = in_eol & accept;
   end

   // Stage 1 registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_y_q     <= '0;
         s1_cb_q    <= '0;
         s1_cr_q    <= '0;
         s1_mode_q  <= 1'b0;
         s1_sof_q   <= 1'b0;
         s1_eol_q   <= 1'b0;
      end else if (en) begin
         s1_valid_q <= s1_valid_d;
         s1_y_q     <= s1_y_d;
         s1_cb_q    <= s1_cb_d;
         s1_cr_q    <= s1_cr_d;
         s1_mode_q  <= s1_mode_d;
         s1_sof_q   <= s1_sof_d;
         s1_eol_q   <= s1_eol_d;
      end
   end

   // ---------------- Stage 2: coefficient multiply ----------------
   logic signed [ACCW-1:0] y_x, cb_x, cr_x;
   logic signed [ACCW-1:0] k_y, k_rcr, k_gcb, k_gcr, k_bcb;
   logic                   s2_valid_q;
   logic signed [ACCW-1:0] s2_py_d, s2_py_q;
   logic signed [ACCW-1:0] s2_prcr_d, s2_prcr_q;
   logic signed [ACCW-1:0] s2_pgcb_d, s2_pgcb_q;
   logic signed [ACCW-1:0] s2_pgcr_d, s2_pgcr_q;
   logic signed [ACCW-1:0] s2_pbcb_d, s2_pbcb_q;
   logic                   s2_sof_q, s2_eol_q;

   // Pick the Q.8 coefficient set for this beat's range and form the five products.
   always_comb begin
      y_x   = {{(ACCW-CW){s1_y_q[CW-1]}}, s1_y_q};
      cb_x  = {{(ACCW-CW){s1_cb_q[CW-1]}}, s1_cb_q};
      cr_x  = {{(ACCW-CW){s1_cr_q[CW-1]}}, s1_cr_q};
      k_y   = s1_mode_q ? ACCW'(298) : ACCW'(256);
      k_rcr = s1_mode_q ? ACCW'(409) : ACCW'(359);
      k_gcb = s1_mode_q ? ACCW'(100) : ACCW'(88);
      k_gcr = s1_mode_q ? ACCW'(208) : ACCW'(183);
      k_bcb = s1_mode_q ? ACCW'(516) : ACCW'(454);
      s2_py_d   = y_x * k_y;
      s2_prcr_d = cr_x * k_rcr;
      s2_pgcb_d = cb_x * k_gcb;
      s2_pgcr_d = cr_x * k_gcr;
      s2_pbcb_d = cb_x * k_bcb;
   end

   // Stage 2 registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_py_q    <= '0;
         s2_prcr_q  <= '0;
         s2_pgcb_q  <= '0;
         s2_pgcr_q  <= '0;
         s2_pbcb_q  <= '0;
         s2_sof_q   <= 1'b0;
         s2_eol_q   <= 1'b0;
      end else if (en) begin
         s2_valid_q <= s1_valid_q;
         s2_py_q    <= s2_py_d;
         s2_prcr_q  <= s2_prcr_d;
         s2_pgcb_q  <= s2_pgcb_d;
         s2_pgcr_q  <= s2_pgcr_d;
         s2_pbcb_q  <= s2_pbcb_d;
         s2_sof_q   <= s1_sof_q;
         s2_eol_q   <= s1_eol_q;
      end
   end

   // ---------------- Stage 3: sum, round, clip ----------------
   logic signed [ACCW-1:0] sum_r, sum_g, sum_b;
   logic signed [ACCW-1:0] sh_r, sh_g, sh_b;
   logic [3*DW-1:0]        out_data_d, out_data_q;
   logic                   out_sof_q, out_eol_q;

   // Round half up, floor-shift out the fraction, then saturate each channel.
   always_comb begin
      sum_r      = s2_py_q + s2_prcr_q + RND;
      sum_g      = s2_py_q - s2_pgcb_q - s2_pgcr_q + RND;
      sum_b      = s2_py_q + s2_pbcb_q + RND;
      sh_r       = sum_r >>> FRAC;
      sh_g       = sum_g >>> FRAC;
      sh_b       = sum_b >>> FRAC;
      out_data_d = {clip(sh_r), clip(sh_g), clip(sh_b)};
   end

   // Output registers; held while the downstream stalls a valid beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
      end else if (en) begin
         out_valid_q <= s2_valid_q;
         out_data_q  <= out_data_d;
         out_sof_q   <= s2_sof_q;
         out_eol_q   <= s2_eol_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// tb/tb_ycbcr2rgb_pipe.sv - randomized self-checking bench for ycbcr2rgb_pipe
module tb_ycbcr2rgb_pipe;

   typedef struct {
      int r;
      int g;
      int b;
      bit sof;
      bit eol;
   } exp_t;

   logic        clk;
   logic        rst;

   logic        in_valid, in_ready, in_mode, in_sof, in_eol;
   logic [23:0] in_data;
   logic        out_valid, out_ready, out_sof, out_eol;
   logic [23:0] out_data;

   logic        in_valid_w, in_ready_w, in_mode_w, in_sof_w, in_eol_w;
   logic [29:0] in_data_w;
   logic        out_valid_w, out_ready_w, out_sof_w, out_eol_w;
   logic [29:0] out_data_w;

   int errors;
   int checks;

   ycbcr2rgb_pipe #(.DW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_sof(in_sof), .in_eol(in_eol),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sof(out_sof), .out_eol(out_eol)
   );

   ycbcr2rgb_pipe #(.DW(10)) dut10 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
      .in_mode(in_mode_w), .in_sof(in_sof_w), .in_eol(in_eol_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
      .out_sof(out_sof_w), .out_eol(out_eol_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int clipv(input int v, input int dw);
      int mx;
      mx = (1 << dw) - 1;
      if (v < 0) return 0;
      if (v > mx) return mx;
      return v;
   endfunction

   // Reference conversion straight from the colour-space equations.
   function automatic void ref_conv(input int dw, input int y, input int cb, input int cr,
                                    input int m, output int r, output int g, output int b);
      int off, yp, cbp, crp, ky, krcr, kgcb, kgcr, kbcb;
      off = 1 << (dw - 1);
      yp  = (m != 0) ? y - (16 << (dw - 8)) : y;
      cbp = cb - off;
      crp = cr - off;
      if (m != 0) begin
         ky = 298; krcr = 409; kgcb = 100; kgcr = 208; kbcb = 516;
      end else begin
         ky = 256; krcr = 359; kgcb = 88;  kgcr = 183; kbcb = 454;
      end
      r = clipv((ky * yp + krcr * crp + 128) >>> 8, dw);
      g = clipv((ky * yp - kgcb * cbp - kgcr * crp + 128) >>> 8, dw);
      b = clipv((ky * yp + kbcb * cbp + 128) >>> 8, dw);
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 24'h0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
         errors++;
         $display("FAIL reset_out8: valid=%b data=%h sof=%b eol=%b expected all zero", out_valid, out_data, out_sof, out_eol);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready8: in_ready=%b expected 1", in_ready);
      end
      checks++;
      if (out_valid_w !== 1'b0 || out_data_w !== 30'h0 || in_ready_w !== 1'b1) begin
         errors++;
         $display("FAIL reset_dw10: valid=%b data=%h ready=%b expected 0/0/1", out_valid_w, out_data_w, in_ready_w);
      end
   endtask

   // Single beat into an idle pipe: checks latency and value.
   task automatic test_vector(input string name, input int y, input int cb, input int cr,
                              input int m, input int er, input int eg, input int eb);
      int lat;
      int r, g, b;
      r = er; g = eg; b = eb;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = {cr[7:0], cb[7:0], y[7:0]};
      in_mode   = m[0];
      in_sof    = 1'b0;
      in_eol    = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: in_ready=%b expected 1", name, in_ready);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 10);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles expected 3", name, lat);
      end
      checks++;
      if (out_data !== {r[7:0], g[7:0], b[7:0]}) begin
         errors++;
         $display("FAIL %s data: got %h expected %h", name, out_data, {r[7:0], g[7:0], b[7:0]});
      end
   endtask

   // Randomized stream with optional input gaps, output stalls and an initial forced stall.
   task automatic run_stream(input string name, input int n, input int mode_sel, input int gap_pct,
                             input int stall_pct, input int hold_first, input bit line_sb);
      exp_t exp_q[$];
      int budget;
      int extra;
      budget = n * 30 + 200;
      @(negedge clk);
      fork
         begin
            int y, cb, cr, m, guard;
            bit s, e, rdy;
            exp_t x;
            guard = 0;
            for (int i = 0; i < n; i++) begin
               while ($urandom_range(99) < gap_pct && guard < budget) begin
                  in_valid = 1'b0;
                  @(negedge clk);
                  guard++;
               end
               y  = $urandom_range(255);
               cb = $urandom_range(255);
               cr = $urandom_range(255);
               case (mode_sel)
                  0:       m = 0;
                  1:       m = 1;
                  2:       m = i % 2;
                  default: m = $urandom_range(1);
               endcase
               if (line_sb) begin
                  s = (i == 0);
                  e = (i == n - 1);
               end else begin
                  s = 1'($urandom_range(1));
                  e = 1'($urandom_range(1));
               end
               in_valid = 1'b1;
               in_data  = {cr[7:0], cb[7:0], y[7:0]};
               in_mode  = m[0];
               in_sof   = s;
               in_eol   = e;
               ref_conv(8, y, cb, cr, m, x.r, x.g, x.b);
               x.sof = s;
               x.eol = e;
               rdy = 1'b0;
               while (!rdy && guard < budget) begin
                  #1;
                  rdy = in_ready;
                  @(posedge clk);
                  if (rdy) exp_q.push_back(x);
                  @(negedge clk);
                  guard++;
               end
            end
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_eol   = 1'b0;
         end
         begin
            int got, cyc, hold_cnt;
            bit ordy, stalled;
            logic [25:0] held;
            exp_t x;
            got = 0; cyc = 0; hold_cnt = 0; stalled = 1'b0; held = '0;
            while (got < n && cyc < budget) begin
               if (out_valid && hold_cnt < hold_first) begin
                  ordy = 1'b0;
                  hold_cnt++;
               end else begin
                  ordy = ($urandom_range(99) >= stall_pct);
               end
               out_ready = ordy;
               if (stalled) begin
                  checks++;
                  if ({out_data, out_sof, out_eol} !== held) begin
                     errors++;
                     $display("FAIL %s stall_hold: got %h expected %h", name, {out_data, out_sof, out_eol}, held);
                  end
               end
               if (out_valid && !ordy) begin
                  #1;
                  checks++;
                  if (in_ready !== 1'b0) begin
                     errors++;
                     $display("FAIL %s stall_ready: in_ready=%b expected 0", name, in_ready);
                  end
                  held = {out_data, out_sof, out_eol};
                  stalled = 1'b1;
               end else begin
                  stalled = 1'b0;
               end
               if (out_valid && ordy) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL %s unexpected_beat: got %h expected no beat", name, out_data);
                  end else begin
                     x = exp_q.pop_front();
                     if ({out_data, out_sof, out_eol} !== {x.r[7:0], x.g[7:0], x.b[7:0], x.sof, x.eol}) begin
                        errors++;
                        $display("FAIL %s beat%0d: got %h sof=%b eol=%b expected %h sof=%b eol=%b", name, got,
                                 out_data, out_sof, out_eol, {x.r[7:0], x.g[7:0], x.b[7:0]}, x.sof, x.eol);
                     end
                  end
                  got++;
               end
               @(negedge clk);
               cyc++;
            end
            checks++;
            if (got != n || exp_q.size() != 0) begin
               errors++;
               $display("FAIL %s count: got %0d beats expected %0d (left %0d)", name, got, n, exp_q.size());
            end
         end
      join
      out_ready = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL %s extra_beats: got %0d expected 0", name, extra);
      end
   endtask

   task automatic test_fixed_vectors;
      int r, g, b;
      test_vector("t1_grey", 128, 128, 128, 0, 128, 128, 128);
      test_vector("t2_sat_hi", 255, 128, 255, 0, 255, 164, 255);
      ref_conv(8, 0, 128, 0, 0, r, g, b);
      test_vector("t2_clip_lo", 0, 128, 0, 0, 0, g, 0);
      test_vector("t3_black", 16, 128, 128, 1, 0, 0, 0);
      test_vector("t3_white", 235, 128, 128, 1, 255, 255, 255);
   endtask

   task automatic test_mode_toggle;
      run_stream("t3_toggle", 100, 2, 10, 10, 0, 1'b0);
   endtask

   task automatic test_backpressure;
      run_stream("t4_backpressure", 5, 0, 0, 0, 4, 1'b0);
   endtask

   task automatic test_sideband;
      run_stream("t5_sideband", 640, 3, 25, 15, 0, 1'b1);
   endtask

   task automatic test_back_to_back;
      run_stream("random_mix", 200, 3, 20, 30, 0, 1'b0);
   endtask

   task automatic test_reset_midstream;
      int r, g, b;
      int late;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {8'd200, 8'd50, 8'(100 + i)};
         in_mode  = 1'b0;
         in_sof   = 1'b1;
         in_eol   = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 24'h0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
         errors++;
         $display("FAIL t6_rst_clear: valid=%b data=%h sof=%b eol=%b expected all zero", out_valid, out_data, out_sof, out_eol);
      end
      late = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) late++;
      end
      checks++;
      if (late != 0) begin
         errors++;
         $display("FAIL t6_discard: got %0d stale beats expected 0", late);
      end
      ref_conv(8, 60, 100, 200, 1, r, g, b);
      test_vector("t6_after_rst", 60, 100, 200, 1, r, g, b);
   endtask

   task automatic test_dw10;
      int y, cb, cr, m, er, eg, eb, lat;
      out_ready_w = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            y = 512; cb = 512; cr = 512; m = 0; er = 512; eg = 512; eb = 512;
         end else begin
            y  = $urandom_range(1023);
            cb = $urandom_range(1023);
            cr = $urandom_range(1023);
            m  = i % 2;
            ref_conv(10, y, cb, cr, m, er, eg, eb);
         end
         @(negedge clk);
         in_valid_w = 1'b1;
         in_data_w  = {cr[9:0], cb[9:0], y[9:0]};
         in_mode_w  = m[0];
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            if (lat == 1) in_valid_w = 1'b0;
         end while (!out_valid_w && lat < 10);
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL dw10_latency%0d: got %0d cycles expected 3", i, lat);
         end
         checks++;
         if (out_data_w !== {er[9:0], eg[9:0], eb[9:0]}) begin
            errors++;
            $display("FAIL dw10_data%0d: got %h expected %h", i, out_data_w, {er[9:0], eg[9:0], eb[9:0]});
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
      in_valid_w = 1'b0; in_data_w = '0; in_mode_w = 1'b0; in_sof_w = 1'b0; in_eol_w = 1'b0; out_ready_w = 1'b1;
      test_reset;
      test_fixed_vectors;
      test_mode_toggle;
      test_backpressure;
      test_sideband;
      test_back_to_back;
      test_reset_midstream;
      test_dw10;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
